// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared FSM state type and sizing helpers for the
// digit-serial adder (digit count and digit-counter width).
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Number of digits (RUN cycles) per operation.
    function automatic int num_digits(input int width, input int digit);
        return width / digit;
    endfunction

    // Digit counter width: clog2(N)+1 keeps N=1 at one bit.
    function automatic int cnt_width(input int width, input int digit);
        return $clog2(width / digit) + 1;
    endfunction

endpackage

// File: rtl/full_adder.sv
// full_adder: single-bit full adder cell.
// Ports: a, b, cin in; sum, cout out.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder_rca_slice.sv
// rca_slice: combinational DIGIT-bit ripple-carry chain of full_adder cells.
// Ports: a, b, cin in; sum, cout (final carry), c_top (carry into top bit) out.
module rca_slice #(
    parameter int DIGIT = 2
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    output logic [DIGIT-1:0] sum,
    output logic             cout,
    output logic             c_top
);

    logic [DIGIT:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < DIGIT; i++) begin : g_bit
        full_adder u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (c[i]),
            .sum  (sum[i]),
            .cout (c[i+1])
        );
    end

    assign cout  = c[DIGIT];
    assign c_top = c[DIGIT-1];

endmodule

// File: rtl/serial_adder.sv
// serial_adder: digit-serial two's-complement adder, DIGIT bits per clock,
// valid/ready on both sides. Optional subtract via macro SERIAL_ADDER_SUB_EN.
// Ports: clk, rst (sync, active-high); in_valid/in_ready, a, b, cin
// [, sub]; out_valid/out_ready, sum, cout, overflow.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int N  = num_digits(WIDTH, DIGIT);
    localparam int CW = cnt_width(WIDTH, DIGIT);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t state;
    state_t state_next;

    logic [WIDTH-1:0]       a_reg;
    logic [WIDTH-1:0]       b_reg;
    logic                   carry;
    logic [CW-1:0]          cnt;
    logic [DIGIT-1:0]       slice_sum;
    logic                   slice_cout;
    logic                   slice_ctop;
    logic                   last_digit;
    logic                   accept;
    logic [WIDTH-1:0]       b_in;
    logic                   c_in;
    logic [WIDTH+DIGIT-1:0] sum_cat;

`ifdef SERIAL_ADDER_SUB_EN
    // A-B = A + ~B + 1; cin is ignored when subtracting.
    assign b_in = sub ? ~b : b;
    assign c_in = sub | cin;
`else
    assign b_in = b;
    assign c_in = cin;
`endif

    rca_slice #(
        .DIGIT (DIGIT)
    ) u_slice (
        .a     (a_reg[DIGIT-1:0]),
        .b     (b_reg[DIGIT-1:0]),
        .cin   (carry),
        .sum   (slice_sum),
        .cout  (slice_cout),
        .c_top (slice_ctop)
    );

    assign last_digit = (cnt == LAST);
    // New digit enters at the MSB end; after N shifts sum is complete.
    assign sum_cat    = {slice_sum, sum};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        accept     = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (last_digit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg    <= '0;
            b_reg    <= '0;
            carry    <= 1'b0;
            cnt      <= '0;
            sum      <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else if (accept) begin
            a_reg <= a;
            b_reg <= b_in;
            carry <= c_in;
            cnt   <= '0;
        end else if (state == RUN) begin
            a_reg <= a_reg >> DIGIT;
            b_reg <= b_reg >> DIGIT;
            carry <= slice_cout;
            sum   <= sum_cat[WIDTH+DIGIT-1:DIGIT];
            cnt   <= cnt + CW'(1);
            if (last_digit) begin
                cout     <= slice_cout;
                overflow <= slice_cout ^ slice_ctop;
            end
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: vector table, hand-written corner sequences and random
// operations checked against an arithmetic reference model.
module tb_serial_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       sub;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] sum;
    logic       cout;
    logic       overflow;

    logic       iv2;
    logic [7:0] a2;
    logic [7:0] b2;
    logic       cin2;
    logic       or2;
    logic       ir8, ir1;
    logic       ov8, ov1;
    logic [7:0] sum8, sum1;
    logic       co8, co1;
    logic       of8, of1;

    serial_adder #(.WIDTH(8), .DIGIT(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef SERIAL_ADDER_SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .overflow  (overflow)
    );

    serial_adder #(.WIDTH(8), .DIGIT(8)) dut8 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (iv2),
        .in_ready  (ir8),
        .a         (a2),
        .b         (b2),
        .cin       (cin2),
`ifdef SERIAL_ADDER_SUB_EN
        .sub       (1'b0),
`endif
        .out_valid (ov8),
        .out_ready (or2),
        .sum       (sum8),
        .cout      (co8),
        .overflow  (of8)
    );

    serial_adder #(.WIDTH(8), .DIGIT(1)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (iv2),
        .in_ready  (ir1),
        .a         (a2),
        .b         (b2),
        .cin       (cin2),
`ifdef SERIAL_ADDER_SUB_EN
        .sub       (1'b0),
`endif
        .out_valid (ov1),
        .out_ready (or2),
        .sum       (sum1),
        .cout      (co1),
        .overflow  (of1)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic; signed overflow from operand signs.
    function automatic void model(input logic [7:0] av, input logic [7:0] bv,
                                  input logic ci, input logic sb,
                                  output logic [7:0] s, output logic co,
                                  output logic ov);
        logic [8:0] t;
        logic [7:0] bb;
        logic       c;
        bb = sb ? ~bv : bv;
        c  = sb ? 1'b1 : ci;
        t  = {1'b0, av} + {1'b0, bb} + {8'd0, c};
        s  = t[7:0];
        co = t[8];
        ov = (av[7] == bb[7]) && (s[7] != av[7]);
    endfunction

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       ci;
        logic       sb;
        logic [7:0] s;
        logic       co;
        logic       ov;
    } vec_t;

    vec_t vecs[$];

    // Issue one operation on the DIGIT=2 instance, check latency and
    // result, hold backpressure for 'hold' cycles, then drain.
    task automatic run_op(input logic [7:0] av, input logic [7:0] bv,
                          input logic ci, input logic sb,
                          input logic [7:0] es, input logic eco,
                          input logic eov, input int hold,
                          input logic keep_valid, input string tag);
        int   lat;
        logic bad;
        logic [7:0] s0;
        logic c0, o0;
        @(negedge clk);
        a   = av;
        b   = bv;
        cin = ci;
`ifdef SERIAL_ADDER_SUB_EN
        sub = sb;
`else
        if (sb) $display("note: subtract request ignored in add-only build");
`endif
        in_valid = 1'b1;
        check({tag, "_in_ready_idle"}, in_ready, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = 8'($urandom);
        b = 8'($urandom);
        lat = 1;
        bad = 1'b0;
        while (!out_valid && lat < 40) begin
            if (in_ready) bad = 1'b1;
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_latency"}, lat, 5);
        check({tag, "_in_ready_busy"}, bad, 1'b0);
        check({tag, "_sum"}, sum, es);
        check({tag, "_cout"}, cout, eco);
        check({tag, "_ovf"}, overflow, eov);
        s0  = sum;
        c0  = cout;
        o0  = overflow;
        bad = 1'b0;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            in_valid = ~in_valid;
            a = 8'($urandom);
            b = 8'($urandom);
            @(posedge clk);
            #1;
            if (sum !== s0 || cout !== c0 || overflow !== o0) bad = 1'b1;
            if (!out_valid || in_ready) bad = 1'b1;
        end
        if (hold > 0) check({tag, "_hold_stable"}, bad, 1'b0);
        @(negedge clk);
        out_ready = 1'b1;
        if (keep_valid) begin
            in_valid = 1'b1;
            a   = 8'h11;
            b   = 8'h22;
            cin = 1'b0;
        end else begin
            in_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, "_ready_after_drain"}, in_ready, 1'b1);
        check({tag, "_valid_after_drain"}, out_valid, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] ra, rb, es;
        logic       rc, rs, eco, eov;
        int         lat8, lat1;

        vecs.push_back('{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0});
        vecs.push_back('{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1});
        vecs.push_back('{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1});
        vecs.push_back('{8'h03, 8'h04, 1'b0, 1'b0, 8'h07, 1'b0, 1'b0});
        vecs.push_back('{8'hA5, 8'h5A, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0});
        vecs.push_back('{8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0});
        vecs.push_back('{8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0});
        vecs.push_back('{8'h80, 8'hFF, 1'b0, 1'b0, 8'h7F, 1'b1, 1'b1});
`ifdef SERIAL_ADDER_SUB_EN
        vecs.push_back('{8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0});
        vecs.push_back('{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1});
        vecs.push_back('{8'h07, 8'h05, 1'b1, 1'b1, 8'h02, 1'b1, 1'b0});
`endif

        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        sub       = 1'b0;
        out_ready = 1'b0;
        iv2       = 1'b0;
        a2        = '0;
        b2        = '0;
        cin2      = 1'b0;
        or2       = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_in_ready", in_ready, 1'b1);
        check("reset_out_valid", out_valid, 1'b0);
        check("reset_sum", sum, 8'h00);
        check("reset_cout", cout, 1'b0);
        check("reset_ovf", overflow, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].ci, vecs[i].sb,
                   vecs[i].s, vecs[i].co, vecs[i].ov, 0, 1'b0,
                   $sformatf("vec%0d", i));
        end

        // Backpressure with in_valid toggling, then operands held valid
        // across the output handshake: accepted only on the next cycle.
        run_op(8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 3, 1'b1, "bp");
        run_op(8'h11, 8'h22, 1'b0, 1'b0, 8'h33, 1'b0, 1'b0, 0, 1'b0,
               "bp_next");

        // Reset during the second RUN cycle discards the operation.
        @(negedge clk);
        a        = 8'h10;
        b        = 8'h20;
        cin      = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_in_ready", in_ready, 1'b1);
        check("rst_mid_out_valid", out_valid, 1'b0);
        check("rst_mid_sum", sum, 8'h00);
        check("rst_mid_cout", cout, 1'b0);
        check("rst_mid_ovf", overflow, 1'b0);
        run_op(8'h03, 8'h04, 1'b0, 1'b0, 8'h07, 1'b0, 1'b0, 0, 1'b0,
               "after_rst");

        // DIGIT=8 and DIGIT=1 instances side by side.
        @(negedge clk);
        a2   = 8'hA5;
        b2   = 8'h5A;
        cin2 = 1'b1;
        iv2  = 1'b1;
        check("d8_in_ready", ir8, 1'b1);
        check("d1_in_ready", ir1, 1'b1);
        @(posedge clk);
        #1;
        iv2  = 1'b0;
        a2   = 8'h00;
        b2   = 8'h00;
        lat8 = 0;
        lat1 = 0;
        for (int k = 1; k <= 20; k++) begin
            if (ov8 && lat8 == 0) lat8 = k;
            if (ov1 && lat1 == 0) lat1 = k;
            if (lat8 != 0 && lat1 != 0) break;
            @(posedge clk);
            #1;
        end
        model(8'hA5, 8'h5A, 1'b1, 1'b0, es, eco, eov);
        check("d8_latency", lat8, 2);
        check("d1_latency", lat1, 9);
        check("d8_sum", sum8, es);
        check("d8_cout", co8, eco);
        check("d8_ovf", of8, eov);
        check("d1_sum", sum1, es);
        check("d1_cout", co1, eco);
        check("d1_ovf", of1, eov);
        @(negedge clk);
        or2 = 1'b1;
        @(posedge clk);
        #1;
        or2 = 1'b0;
        check("d8_drain_ready", ir8, 1'b1);
        check("d1_drain_ready", ir1, 1'b1);

        for (int i = 0; i < 30; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rc = 1'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
            rs = 1'($urandom);
`else
            rs = 1'b0;
`endif
            model(ra, rb, rc, rs, es, eco, eov);
            run_op(ra, rb, rc, rs, es, eco, eov, int'($urandom_range(0, 2)),
                   1'b0, $sformatf("rnd%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
